pipe_hazard_ctrl: RTL and testbench

//  Pipeline interlock/flush sequencer for the dual-issue (A/B) 5-stage core.
//  EX operand forwarding only takes MEM-stage ALU results and WB write data, so

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/hazard_match.sv | 27 ++
 rtl/pipe_hazard_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the dual-issue pipeline hazard controller.
package pipe_pkg;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_MUL = 2'd2,
    RES_DIV = 2'd3
  } res_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIV_WAIT = 2'd1,
    DC_WAIT  = 2'd2
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Only ALU results are forwardable from MEM; everything else is late.
  function automatic logic is_late_result(input logic [1:0] sel);
    return res_sel_t'(sel) != RES_ALU;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one ID source register against the four EX/MEM producers and
// flags a hit when the producer's result cannot be forwarded in time.
module hazard_match
  import pipe_pkg::*;
(
  input  logic            re_i,
  input  logic [4:0]      raddr_i,
  input  logic [3:0][4:0] prod_waddr_i,
  input  logic [3:0]      prod_we_i,
  input  logic [3:0][1:0] prod_sel_i,
  output logic            hit_o
);

  logic [3:0] match_s;

  // Per-producer match of a late (non-ALU) result on the same register.
  always_comb begin
    match_s = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      match_s[k] = prod_we_i[k] && (prod_waddr_i[k] == raddr_i) &&
                   is_late_result(prod_sel_i[k]);
    end
  end

  assign hit_o = re_i && (raddr_i != REG_ZERO) && (|match_s);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Interlock/flush sequencer: load-use stalls, divider and D-cache freezes,
// and branch-redirect flushes deferred across a freeze.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int DIV_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [3:0][4:0]  id_raddr_i,
  input  logic [3:0]       id_re_i,
  input  logic [4:0]       ex_waddr_a_i,
  input  logic [4:0]       ex_waddr_b_i,
  input  logic             ex_we_a_i,
  input  logic             ex_we_b_i,
  input  res_sel_t         ex_res_sel_a_i,
  input  res_sel_t         ex_res_sel_b_i,
  input  logic [4:0]       mem_waddr_a_i,
  input  logic [4:0]       mem_waddr_b_i,
  input  logic             mem_we_a_i,
  input  logic             mem_we_b_i,
  input  res_sel_t         mem_res_sel_a_i,
  input  res_sel_t         mem_res_sel_b_i,
  input  logic             ex_div_start_i,
  input  logic             div_done_i,
  input  logic             mem_dcache_miss_i,
  input  logic             dcache_ready_i,
  input  logic             ex_br_redirect_i,
  output logic             stall_pc_o,
  output logic             stall_if_id_o,
  output logic             stall_id_ex_o,
  output logic             stall_ex_mem_o,
  output logic             stall_mem_wb_o,
  output logic             bubble_ex_o,
  output logic             bubble_mem_o,
  output logic             bubble_wb_o,
  output logic             flush_if_id_o,
  output logic             flush_id_ex_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic             err_div_timeout_o
);

  localparam int DC_W = $clog2(DIV_TIMEOUT);

  hz_state_t        state_q, state_d;
  logic             pend_flush_q, pend_flush_d;
  logic             div_pend_q, div_pend_d;
  logic [DC_W-1:0]  div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             err_q, err_d;

  logic [3:0][4:0]  prod_waddr_s;
  logic [3:0]       prod_we_s;
  logic [3:0][1:0]  prod_sel_s;
  logic [3:0]       hit_s;
  logic             load_use_s;
  logic [4:0]       stall_s;
  logic [2:0]       bubble_s;
  logic             flush_s;

  assign prod_waddr_s = {mem_waddr_b_i, mem_waddr_a_i, ex_waddr_b_i, ex_waddr_a_i};
  assign prod_we_s    = {mem_we_b_i, mem_we_a_i, ex_we_b_i, ex_we_a_i};
  assign prod_sel_s   = {mem_res_sel_b_i, mem_res_sel_a_i, ex_res_sel_b_i, ex_res_sel_a_i};

  for (genvar g = 0; g < 4; g++) begin : g_match
    hazard_match u_match (
      .re_i         (id_re_i[g]),
      .raddr_i      (id_raddr_i[g]),
      .prod_waddr_i (prod_waddr_s),
      .prod_we_i    (prod_we_s),
      .prod_sel_i   (prod_sel_s),
      .hit_o        (hit_s[g])
    );
  end

  assign load_use_s = |hit_s;

  // Next-state and stage-control decode; stall_s is {pc,if_id,id_ex,ex_mem,mem_wb}.
  always_comb begin
    state_d      = state_q;
    pend_flush_d = pend_flush_q;
    div_pend_d   = div_pend_q;
    err_d        = err_q;
    stall_s      = 5'b00000;
    bubble_s     = 3'b000;
    flush_s      = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_dcache_miss_i) begin
          stall_s      = 5'b11111;
          bubble_s     = 3'b001;
          state_d      = DC_WAIT;
          div_pend_d   = ex_div_start_i;
          pend_flush_d = pend_flush_q | ex_br_redirect_i;
        end else if (ex_div_start_i) begin
          state_d      = DIV_WAIT;
          pend_flush_d = pend_flush_q | ex_br_redirect_i;
          if (load_use_s) begin
            stall_s  = 5'b11100;
            bubble_s = 3'b100;
          end else begin
            stall_s  = 5'b00000;
          end
        end else if (ex_br_redirect_i || pend_flush_q) begin
          flush_s      = 1'b1;
          pend_flush_d = 1'b0;
        end else if (load_use_s) begin
          stall_s  = 5'b11100;
          bubble_s = 3'b100;
        end else begin
          stall_s  = 5'b00000;
        end
      end
      DIV_WAIT: begin
        pend_flush_d = pend_flush_q | ex_br_redirect_i;
        if (div_done_i) begin
          state_d = RUN;
        end else begin
          stall_s  = 5'b11110;
          bubble_s = 3'b010;
          if (div_cnt_q == DC_W'(DIV_TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = RUN;
          end else begin
            state_d = DIV_WAIT;
          end
        end
      end
      DC_WAIT: begin
        stall_s      = 5'b11111;
        bubble_s     = 3'b001;
        pend_flush_d = pend_flush_q | ex_br_redirect_i;
        if (dcache_ready_i) begin
          state_d    = (div_pend_q && !div_done_i) ? DIV_WAIT : RUN;
          div_pend_d = 1'b0;
        end else if (div_done_i) begin
          div_pend_d = 1'b0;
        end else begin
          state_d    = DC_WAIT;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
    // Counter is zero outside DIV_WAIT, so entering the state starts at 0.
    div_cnt_d = ((state_q == DIV_WAIT) && (state_d == DIV_WAIT)) ?
                div_cnt_q + DC_W'(1) : {DC_W{1'b0}};
    stall_cnt_d = (stall_s[4] && (stall_cnt_q != {CNT_W{1'b1}})) ?
                  stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= RUN;
      pend_flush_q <= 1'b0;
      div_pend_q   <= 1'b0;
      div_cnt_q    <= {DC_W{1'b0}};
      stall_cnt_q  <= {CNT_W{1'b0}};
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_flush_q <= pend_flush_d;
      div_pend_q   <= div_pend_d;
      div_cnt_q    <= div_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      err_q        <= err_d;
    end
  end

  assign stall_pc_o        = stall_s[4] & ~rst_i;
  assign stall_if_id_o     = stall_s[3] & ~rst_i;
  assign stall_id_ex_o     = stall_s[2] & ~rst_i;
  assign stall_ex_mem_o    = stall_s[1] & ~rst_i;
  assign stall_mem_wb_o    = stall_s[0] & ~rst_i;
  assign bubble_ex_o       = bubble_s[2] & ~rst_i;
  assign bubble_mem_o      = bubble_s[1] & ~rst_i;
  assign bubble_wb_o       = bubble_s[0] & ~rst_i;
  assign flush_if_id_o     = flush_s & ~rst_i;
  assign flush_id_ex_o     = flush_s & ~rst_i;
  assign stall_cnt_o       = stall_cnt_q;
  assign err_div_timeout_o = err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hand-computed control vectors per cycle.
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  localparam int CNT_W = 4;
  // Control vector order: stall pc,if_id,id_ex,ex_mem,mem_wb | bubble ex,mem,wb | flush if_id,id_ex
  localparam logic [9:0] NONE = 10'b00000_000_00;
  localparam logic [9:0] LU   = 10'b11100_100_00;
  localparam logic [9:0] DIVF = 10'b11110_010_00;
  localparam logic [9:0] DCF  = 10'b11111_001_00;
  localparam logic [9:0] FL   = 10'b00000_000_11;

  logic clk = 1'b0;
  logic rst;
  logic [3:0][4:0] id_raddr;
  logic [3:0] id_re;
  logic [4:0] ex_waddr_a, ex_waddr_b, mem_waddr_a, mem_waddr_b;
  logic ex_we_a, ex_we_b, mem_we_a, mem_we_b;
  res_sel_t ex_sel_a, ex_sel_b, mem_sel_a, mem_sel_b;
  logic ex_div_start, div_done, mem_dcache_miss, dcache_ready, ex_br_redirect;
  logic s_pc, s_if, s_id, s_ex, s_mem, b_ex, b_mem, b_wb, f_if, f_id;
  logic [CNT_W-1:0] stall_cnt;
  logic err;
  logic [9:0] ctl;
  int n_chk = 0;
  int n_fail = 0;

  assign ctl = {s_pc, s_if, s_id, s_ex, s_mem, b_ex, b_mem, b_wb, f_if, f_id};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.DIV_TIMEOUT(12), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .id_raddr_i(id_raddr), .id_re_i(id_re),
    .ex_waddr_a_i(ex_waddr_a), .ex_waddr_b_i(ex_waddr_b),
    .ex_we_a_i(ex_we_a), .ex_we_b_i(ex_we_b),
    .ex_res_sel_a_i(ex_sel_a), .ex_res_sel_b_i(ex_sel_b),
    .mem_waddr_a_i(mem_waddr_a), .mem_waddr_b_i(mem_waddr_b),
    .mem_we_a_i(mem_we_a), .mem_we_b_i(mem_we_b),
    .mem_res_sel_a_i(mem_sel_a), .mem_res_sel_b_i(mem_sel_b),
    .ex_div_start_i(ex_div_start), .div_done_i(div_done),
    .mem_dcache_miss_i(mem_dcache_miss), .dcache_ready_i(dcache_ready),
    .ex_br_redirect_i(ex_br_redirect),
    .stall_pc_o(s_pc), .stall_if_id_o(s_if), .stall_id_ex_o(s_id),
    .stall_ex_mem_o(s_ex), .stall_mem_wb_o(s_mem),
    .bubble_ex_o(b_ex), .bubble_mem_o(b_mem), .bubble_wb_o(b_wb),
    .flush_if_id_o(f_if), .flush_id_ex_o(f_id),
    .stall_cnt_o(stall_cnt), .err_div_timeout_o(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    id_raddr = '0; id_re = 4'b0000;
    ex_waddr_a = 5'd0; ex_waddr_b = 5'd0; mem_waddr_a = 5'd0; mem_waddr_b = 5'd0;
    ex_we_a = 1'b0; ex_we_b = 1'b0; mem_we_a = 1'b0; mem_we_b = 1'b0;
    ex_sel_a = RES_ALU; ex_sel_b = RES_ALU; mem_sel_a = RES_ALU; mem_sel_b = RES_ALU;
    ex_div_start = 1'b0; div_done = 1'b0; mem_dcache_miss = 1'b0;
    dcache_ready = 1'b0; ex_br_redirect = 1'b0;
  endtask

  task automatic nxt();
    @(negedge clk);
    clr();
  endtask

  initial begin
    clr();
    rst = 1'b1;
    // Reset held with a live hazard on the inputs: outputs must stay low.
    nxt(); ex_we_a = 1'b1; ex_waddr_a = 5'd5; ex_sel_a = RES_MEM;
    id_re[0] = 1'b1; id_raddr[0] = 5'd5; #1;
    chk("reset_gated", 32'(ctl), 32'(NONE));
    nxt(); rst = 1'b0; #1;
    chk("reset_ctl", 32'(ctl), 32'(NONE));
    chk("reset_cnt", 32'(stall_cnt), 32'd0);
    chk("reset_err", 32'(err), 32'd0);

    // Load r5 in EX, ID a1 reads r5: two stall cycles while it drains.
    nxt(); ex_we_a = 1'b1; ex_waddr_a = 5'd5; ex_sel_a = RES_MEM;
    id_re[0] = 1'b1; id_raddr[0] = 5'd5; #1;
    chk("lu_ex", 32'(ctl), 32'(LU));
    nxt(); mem_we_a = 1'b1; mem_waddr_a = 5'd5; mem_sel_a = RES_MEM;
    id_re[0] = 1'b1; id_raddr[0] = 5'd5; #1;
    chk("lu_mem", 32'(ctl), 32'(LU));
    nxt(); id_re[0] = 1'b1; id_raddr[0] = 5'd5; #1;
    chk("lu_release", 32'(ctl), 32'(NONE));
    chk("lu_cnt", 32'(stall_cnt), 32'd2);
    // MUL on lane B in EX feeding source b2.
    nxt(); ex_we_b = 1'b1; ex_waddr_b = 5'd17; ex_sel_b = RES_MUL;
    id_re[3] = 1'b1; id_raddr[3] = 5'd17; #1;
    chk("lu_mul_b2", 32'(ctl), 32'(LU));
    // Forwardable or irrelevant producers must not stall.
    nxt(); ex_we_a = 1'b1; ex_waddr_a = 5'd5; ex_sel_a = RES_ALU;
    id_re[0] = 1'b1; id_raddr[0] = 5'd5; #1;
    chk("alu_ex_nostall", 32'(ctl), 32'(NONE));
    nxt(); ex_we_a = 1'b1; ex_waddr_a = 5'd0; ex_sel_a = RES_MEM;
    id_re[1] = 1'b1; id_raddr[1] = 5'd0; #1;
    chk("r0_nostall", 32'(ctl), 32'(NONE));
    nxt(); mem_we_b = 1'b1; mem_waddr_b = 5'd9; mem_sel_b = RES_DIV;
    id_re[2] = 1'b0; id_raddr[2] = 5'd9; #1;
    chk("re0_nostall", 32'(ctl), 32'(NONE));
    // Redirect wins over a simultaneous load-use hit.
    nxt(); ex_br_redirect = 1'b1; mem_we_b = 1'b1; mem_waddr_b = 5'd9; mem_sel_b = RES_DIV;
    id_re[2] = 1'b1; id_raddr[2] = 5'd9; #1;
    chk("redirect_over_lu", 32'(ctl), 32'(FL));
    chk("redirect_cnt", 32'(stall_cnt), 32'd3);

    nxt(); rst = 1'b1;
    nxt(); rst = 1'b0; #1;
    chk("rst2_cnt", 32'(stall_cnt), 32'd0);

    // Divide: 10 frozen cycles, done on the 11th DIV_WAIT cycle.
    nxt(); ex_div_start = 1'b1; #1;
    chk("div_start", 32'(ctl), 32'(NONE));
    for (int i = 0; i < 10; i++) begin
      nxt(); #1;
      chk("div_wait", 32'(ctl), 32'(DIVF));
    end
    nxt(); div_done = 1'b1; #1;
    chk("div_done", 32'(ctl), 32'(NONE));
    nxt(); #1;
    chk("div_run", 32'(ctl), 32'(NONE));
    chk("div_cnt10", 32'(stall_cnt), 32'd10);

    // D-cache miss, redirect in cycle 3, ready in cycle 6; counter saturates.
    nxt(); mem_dcache_miss = 1'b1; #1;
    chk("dc_miss", 32'(ctl), 32'(DCF));
    nxt(); #1; chk("dc_wait1", 32'(ctl), 32'(DCF));
    nxt(); #1; chk("dc_wait2", 32'(ctl), 32'(DCF));
    nxt(); ex_br_redirect = 1'b1; #1;
    chk("dc_redirect_held", 32'(ctl), 32'(DCF));
    chk("dc_cnt13", 32'(stall_cnt), 32'd13);
    nxt(); #1; chk("dc_wait4", 32'(ctl), 32'(DCF));
    nxt(); #1; chk("dc_wait5", 32'(ctl), 32'(DCF));
    nxt(); dcache_ready = 1'b1; #1;
    chk("dc_ready", 32'(ctl), 32'(DCF));
    nxt(); #1;
    chk("dc_pend_flush", 32'(ctl), 32'(FL));
    nxt(); #1;
    chk("dc_after_flush", 32'(ctl), 32'(NONE));
    chk("cnt_saturated", 32'(stall_cnt), 32'd15);

    // Miss together with div start: DC freeze first, then the divide.
    nxt(); mem_dcache_miss = 1'b1; ex_div_start = 1'b1; #1;
    chk("mdiv_miss", 32'(ctl), 32'(DCF));
    nxt(); #1; chk("mdiv_dcwait", 32'(ctl), 32'(DCF));
    nxt(); dcache_ready = 1'b1; #1; chk("mdiv_ready", 32'(ctl), 32'(DCF));
    nxt(); #1; chk("mdiv_divwait", 32'(ctl), 32'(DIVF));
    nxt(); div_done = 1'b1; #1; chk("mdiv_done", 32'(ctl), 32'(NONE));
    // Divider finishes during the DC freeze: no DIV_WAIT afterwards.
    nxt(); mem_dcache_miss = 1'b1; ex_div_start = 1'b1; #1;
    chk("mdone_miss", 32'(ctl), 32'(DCF));
    nxt(); div_done = 1'b1; #1; chk("mdone_done", 32'(ctl), 32'(DCF));
    nxt(); dcache_ready = 1'b1; #1; chk("mdone_ready", 32'(ctl), 32'(DCF));
    nxt(); #1; chk("mdone_run", 32'(ctl), 32'(NONE));

    // Two redirects inside DIV_WAIT collapse into one deferred flush.
    nxt(); ex_div_start = 1'b1; #1;
    nxt(); ex_br_redirect = 1'b1; #1; chk("dredir1", 32'(ctl), 32'(DIVF));
    nxt(); ex_br_redirect = 1'b1; #1; chk("dredir2", 32'(ctl), 32'(DIVF));
    nxt(); div_done = 1'b1; #1; chk("dredir_done", 32'(ctl), 32'(NONE));
    nxt(); #1; chk("dredir_flush", 32'(ctl), 32'(FL));
    nxt(); #1; chk("dredir_single", 32'(ctl), 32'(NONE));

    // Watchdog: DIV_TIMEOUT=12, no done.
    nxt(); ex_div_start = 1'b1; #1;
    for (int i = 0; i < 12; i++) begin
      nxt(); #1;
      chk("to_wait", 32'(ctl), 32'(DIVF));
    end
    chk("to_err_pre", 32'(err), 32'd0);
    nxt(); #1;
    chk("to_run", 32'(ctl), 32'(NONE));
    chk("to_err", 32'(err), 32'd1);
    nxt(); #1;
    chk("to_err_sticky", 32'(err), 32'd1);

    // Reset inside DC_WAIT with a pending flush: nothing survives.
    nxt(); mem_dcache_miss = 1'b1; #1;
    nxt(); ex_br_redirect = 1'b1; #1; chk("rdc_wait", 32'(ctl), 32'(DCF));
    nxt(); rst = 1'b1; #1; chk("rdc_in_rst", 32'(ctl), 32'(NONE));
    nxt(); rst = 1'b0; #1;
    chk("rdc_no_flush", 32'(ctl), 32'(NONE));
    chk("rdc_err_clr", 32'(err), 32'd0);
    chk("rdc_cnt_clr", 32'(stall_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
